// File: rtl/key_mix_engine.sv
// key_mix_engine: RC5-family key-schedule mixing pass over externally held
// S and L arrays through synchronous-read memory ports.
//   A = S[i] = (S[i] + A + B) <<< 3
//   B = L[j] = (L[j] + A + B) <<< (A + B)
// Each iteration takes three cycles (READ, WR_S, WR_L) and the pass runs
// N = 3*max(t,c) iterations, followed by a one-cycle DONE pulse.
// Optional build macro KEY_MIX_ABORT_EN adds an abort input that returns the
// engine to IDLE from any active state without a write or a done pulse.
module key_mix_engine #(
    parameter int w        = 32,
    parameter int t        = 26,
    parameter int c        = 4,
    parameter int t_length = $clog2(t),
    parameter int c_length = (c > 1) ? $clog2(c) : 1
) (
    input  logic                clk1,
    input  logic                rst,
    input  logic                start,
`ifdef KEY_MIX_ABORT_EN
    input  logic                abort,
`endif
    input  logic [w-1:0]        S_sub_i,
    input  logic [w-1:0]        L_sub_i,
    output logic [t_length-1:0] S_address,
    output logic [c_length-1:0] L_address,
    output logic [w-1:0]        S_sub_i_prima,
    output logic [w-1:0]        L_sub_i_prima,
    output logic                S_we,
    output logic                L_we,
    output logic                busy,
    output logic                done
);

    localparam int RW  = $clog2(w);
    localparam int N   = 3 * ((t > c) ? t : c);
    localparam int K_W = $clog2(N);

    localparam logic [t_length-1:0] I_LAST = t_length'(t - 1);
    localparam logic [c_length-1:0] J_LAST = c_length'(c - 1);
    localparam logic [K_W-1:0]      K_LAST = K_W'(N - 1);
    localparam logic [RW-1:0]       ROT_A  = RW'(3);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        WR_S = 3'd2,
        WR_L = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [w-1:0]          a_q, a_d;
    logic [w-1:0]          b_q, b_d;
    logic [w-1:0]          lq_q, lq_d;
    logic [t_length-1:0]   i_q, i_d;
    logic [c_length-1:0]   j_q, j_d;
    logic [K_W-1:0]        k_q, k_d;

    logic                  abort_w;
    logic [w-1:0]          sum_s;
    logic [w-1:0]          a_new;
    logic [w-1:0]          sum_ab;
    logic [w-1:0]          b_new;

    // Rotate left; duplicating the word makes a zero amount the identity.
    function automatic logic [w-1:0] rotl(input logic [w-1:0] x,
                                          input logic [RW-1:0] r);
        logic [2*w-1:0] d;
        d = {x, x} << r;
        return d[2*w-1:w];
    endfunction

`ifdef KEY_MIX_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // WR_S uses fresh S read data; WR_L uses the already-updated A and the
    // L word captured during WR_S.
    assign sum_s  = S_sub_i + a_q + b_q;
    assign a_new  = rotl(sum_s, ROT_A);
    assign sum_ab = a_q + b_q;
    assign b_new  = rotl(lq_q + sum_ab, sum_ab[RW-1:0]);

    assign S_address = i_q;
    assign L_address = j_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

    // Next-state, datapath updates and write strobes.
    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        lq_d          = lq_q;
        i_d           = i_q;
        j_d           = j_q;
        k_d           = k_q;
        S_we          = 1'b0;
        L_we          = 1'b0;
        S_sub_i_prima = '0;
        L_sub_i_prima = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = '0;
                    b_d     = '0;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    state_d = READ;
                end
            end
            READ: begin
                state_d = WR_S;
            end
            WR_S: begin
                S_we          = 1'b1;
                S_sub_i_prima = a_new;
                a_d           = a_new;
                lq_d          = L_sub_i;
                state_d       = WR_L;
            end
            WR_L: begin
                L_we          = 1'b1;
                L_sub_i_prima = b_new;
                b_d           = b_new;
                i_d           = (i_q == I_LAST) ? '0 : i_q + 1'b1;
                j_d           = (j_q == J_LAST) ? '0 : j_q + 1'b1;
                k_d           = k_q + 1'b1;
                state_d       = (k_q == K_LAST) ? DONE : READ;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort suppresses any write in the current cycle and freezes state.
        if (abort_w && (state_q != IDLE)) begin
            state_d       = IDLE;
            a_d           = a_q;
            b_d           = b_q;
            lq_d          = lq_q;
            i_d           = i_q;
            j_d           = j_q;
            k_d           = k_q;
            S_we          = 1'b0;
            L_we          = 1'b0;
            S_sub_i_prima = '0;
            L_sub_i_prima = '0;
        end
    end

    // State and working registers with synchronous reset.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            lq_q    <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            lq_q    <= lq_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
        end
    end

endmodule

// File: doc/key_mix_engine.md
# key_mix_engine

Parametrised RC5-family key-schedule mixing engine that runs the final mixing pass, A = S[i] = (S[i]+A+B) <<< 3 and B = L[j] = (L[j]+A+B) <<< (A+B), over externally held S and L arrays. It sits after the L-loading (key bytes to words) and S-initialisation stages and drives the same S/L memory ports. Word width, S depth and L depth are parameters. The engine runs on a single clock with an explicit start/busy/done handshake.

## Interface
- w, 32, word width in bits; power of two; legal values 16, 32, 64.
- t, 26, S array depth.
- c, 4, L array depth; 1 ≤ c.
- t_length, $clog2(t), S address width.
- c_length, $clog2(c) (minimum 1), L address width.
- clk1  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to run one full mixing pass; sampled only in IDLE.
- S_sub_i  in  w  S read data; valid one cycle after S_address is presented.
- L_sub_i  in  w  L read data; valid one cycle after L_address is presented.
- S_address  out  t_length  S read/write address (index i).
- L_address  out  c_length  L read/write address (index j).
- S_sub_i_prima  out  w  S write data.
- L_sub_i_prima  out  w  L write data.
- S_we  out  1  S write enable.
- L_we  out  1  L write enable.
- busy  out  1  high from the start-accept edge until DONE is left.
- done  out  1  single-cycle completion pulse.
- abort  in  1  present only with KEY_MIX_ABORT_EN.

## Operation
- Iteration count is N = 3·max(t,c); k counts 0..N-1.
- Indices:
  - i wraps from t-1 to 0; j wraps from c-1 to 0.
  - Both advance once per iteration.
- FSM states:
  - IDLE: on start, clear A, B, i, j, k, then go to READ.
  - READ: drive S_address=i and L_address=j; no writes.
  - WR_S: A_new = rotl(S_sub_i+A+B, 3). Drive S_sub_i_prima=A_new and S_we=1. Load A←A_new. Capture L_sub_i into register Lq.
  - WR_L: s = A+B; B_new = rotl(Lq+s, s[log2(w)-1:0]). Drive L_sub_i_prima=B_new and L_we=1. Load B←B_new. Advance i, j, k. Go to DONE if k==N-1, else READ.
  - DONE: done=1 for one cycle, then IDLE.
- Addresses stay constant for all three cycles of an iteration.
- Arithmetic is modulo 2^w with no carry out. A rotation amount of 0 is the identity.
- Memories are synchronous-read with one-cycle latency. Write data from WR_S is not re-read within the same iteration.
- start while busy is ignored. start held high in DONE is not accepted until the engine is back in IDLE.

## Timing
- Reset values:
  - Outputs: S_we=0, L_we=0, busy=0, done=0, S_address=0, L_address=0, S_sub_i_prima=0, L_sub_i_prima=0.
  - Internal: A=B=Lq=0, state IDLE.
- Write data and write enables are combinational from state and registers. They are valid only while the matching write enable is high.
- Schedule, counting the start-sampling edge as cycle 0: iteration n occupies cycles 3n+1 (READ), 3n+2 (WR_S) and 3n+3 (WR_L). done is high in cycle 3N+1, and busy falls after that cycle.
- rst mid-pass: on the next edge, state goes to IDLE, all writes stop and A/B are cleared. Partially updated arrays are left as-is.

## Configuration
- KEY_MIX_ABORT_EN defined:
  - The abort port exists.
  - abort=1 in any non-IDLE state forces IDLE on the next edge, with no write issued that cycle and no done pulse.
  - busy falls on that same edge.
- KEY_MIX_ABORT_EN undefined: no abort port; a pass always runs to DONE unless rst is asserted.

## Test plan
- w=32, A=B=0, S[0]=0xB7E15163, L[0]=0 → first WR_S writes S[0]=0xBF0A8B1D; first WR_L writes L[0]=0xB7E15163.
- t=26, c=4, start pulse at cycle 0 → 78 iterations, 78 S writes and 78 L writes, done high exactly in cycle 235, single cycle.
- t=3, c=2 → N=9. S_address sequence is 0,1,2,0,1,2,0,1,2. L_address sequence is 0,1,0,1,…. done is high in cycle 28.
- start re-pulsed during iteration 5, and start held high through DONE → no restart and identical write trace. A new pass begins only from IDLE.
- rst asserted in a WR_S cycle mid-pass → S_we=0 on the next cycle, busy=0, no done pulse. A subsequent start reproduces the reference write trace from iteration 0.
- With KEY_MIX_ABORT_EN: abort in WR_L of iteration 10 → no L write that cycle, IDLE on the next edge, done never pulses. A new start restarts the pass from k=0.
